// File: rtl/sisc_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : sisc_fetch_unit
//  Purpose  : SISC PC / IR / status datapath with branch resolution and an
//             instruction fetch FSM. Optional imem wait-state handshake is
//             enabled with the SISC_IMEM_WAIT_EN macro.
//  Revision : 1.0  initial release
// ============================================================================
module sisc_fetch_unit #(
    parameter int PC_W    = 16,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst_f,
    input  logic               pc_write,
    input  logic               pc_sel,
    input  logic               br_sel,
    input  logic               ir_load,
    input  logic               stat_load,
    input  logic [3:0]         alu_stat,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               imem_rdy,
    output logic [INSTR_W-1:0] instr,
    output logic [3:0]         opcode,
    output logic [3:0]         mm,
    output logic [3:0]         stat,
    output logic               busy
);

    localparam logic [3:0] C_OP_BRA = 4'd4;
    localparam logic [3:0] C_OP_BRR = 4'd5;
    localparam logic [3:0] C_OP_BNE = 4'd6;
    localparam logic [3:0] C_OP_BNR = 4'd7;

    localparam logic [0:0] C_ST_IDLE = 1'b0;
    localparam logic [0:0] C_ST_WAIT = 1'b1;

    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_ir;
    logic [3:0]         r_stat;
    logic [0:0]         r_state;
    logic [0:0]         w_state_nxt;
    logic               w_ir_we;
    logic               w_busy;
    logic               w_rdy;
    logic               w_hit;
    logic               w_taken;
    logic [PC_W-1:0]    w_imm_zx;
    logic [PC_W-1:0]    w_imm_sx;
    logic [PC_W-1:0]    w_pc_nxt;

`ifdef SISC_IMEM_WAIT_EN
    assign w_rdy = imem_rdy;
`else
    logic w_unused_rdy;
    assign w_unused_rdy = imem_rdy;
    assign w_rdy        = 1'b1;
`endif

    // Fetch FSM: state register
    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f)
            r_state <= C_ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Fetch FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            C_ST_IDLE: if (ir_load && !w_rdy) w_state_nxt = C_ST_WAIT;
            C_ST_WAIT: if (w_rdy)             w_state_nxt = C_ST_IDLE;
            default:                          w_state_nxt = C_ST_IDLE;
        endcase
    end

    // Fetch FSM: outputs
    always_comb begin
        w_ir_we = 1'b0;
        w_busy  = 1'b0;
        case (r_state)
            C_ST_IDLE: w_ir_we = ir_load && w_rdy;
            C_ST_WAIT: begin
                w_busy  = 1'b1;
                w_ir_we = w_rdy;
            end
            default: ;
        endcase
    end

    // Branch condition always evaluates against the stat held before this edge
    always_comb begin
        w_hit   = |(r_ir[27:24] & r_stat);
        w_taken = 1'b0;
        case (r_ir[31:28])
            C_OP_BRA, C_OP_BRR: w_taken = w_hit;
            C_OP_BNE, C_OP_BNR: w_taken = !w_hit;
            default:            w_taken = 1'b0;
        endcase
    end

    assign w_imm_zx = PC_W'(r_ir[15:0]);
    assign w_imm_sx = PC_W'($signed(r_ir[15:0]));

    always_comb begin
        w_pc_nxt = r_pc;
        if (!pc_sel)
            w_pc_nxt = r_pc + PC_W'(1);
        else if (w_taken)
            w_pc_nxt = br_sel ? (r_pc + w_imm_sx) : w_imm_zx;
    end

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            r_pc   <= '0;
            r_ir   <= '0;
            r_stat <= '0;
        end else begin
            if (pc_write && !w_busy)
                r_pc <= w_pc_nxt;
            if (w_ir_we)
                r_ir <= imem_data;
            if (stat_load)
                r_stat <= alu_stat;
        end
    end

    assign imem_addr = r_pc;
    assign instr     = r_ir;
    assign opcode    = r_ir[31:28];
    assign mm        = r_ir[27:24];
    assign stat      = r_stat;
    assign busy      = w_busy;

endmodule
`default_nettype wire
